bcd_scan_display: RTL and testbench

- Downstream consumer of the cascaded decade (mod-10) counter chain.
- Captures NDIG packed BCD digits on a latch strobe into a hold register.
- Time-multiplexes the held digits onto one shared 7-segment bus with a rotating digit enable.
- Drives the board-level multiplexed LED display; registered outputs, single clock domain.

---
 rtl/bcd_disp_pkg.sv | 20 ++
 rtl/bcd_to_seg7.sv | 28 ++
 rtl/bcd_scan_display.sv | 114 +++++++++++
 tb/tb_bcd_scan_display.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared types and 7-segment patterns ({g,f,e,d,c,b,a}, high-true) for the BCD scan display.
package bcd_disp_pkg;

  typedef logic [6:0] seg7_t;
  typedef logic [3:0] bcd_t;

  localparam seg7_t SEG_0    = 7'h3F;
  localparam seg7_t SEG_1    = 7'h06;
  localparam seg7_t SEG_2    = 7'h5B;
  localparam seg7_t SEG_3    = 7'h4F;
  localparam seg7_t SEG_4    = 7'h66;
  localparam seg7_t SEG_5    = 7'h6D;
  localparam seg7_t SEG_6    = 7'h7D;
  localparam seg7_t SEG_7    = 7'h07;
  localparam seg7_t SEG_8    = 7'h7F;
  localparam seg7_t SEG_9    = 7'h6F;
  localparam seg7_t SEG_DASH = 7'h40;
  localparam seg7_t SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to high-true 7-segment decoder; non-BCD nibbles show a dash and flag err.
module bcd_to_seg7
  import bcd_disp_pkg::*;
(
  input  bcd_t  bcd,
  output seg7_t seg,
  output logic  err
);

  always_comb begin
    seg = SEG_DASH;
    err = (bcd > 4'd9);
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_scan_display.sv
// Multiplexed 7-segment driver: latches NDIG BCD digits and scans them onto a shared bus.
// Optional leading-zero blanking is enabled by defining BCD_SCAN_LZ_BLANK_EN.
module bcd_scan_display
  import bcd_disp_pkg::*;
#(
  parameter int unsigned NDIG       = 4,
  parameter int unsigned PRESCALE   = 1000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [4*NDIG-1:0] digits_in,
  input  logic              latch,
  output logic [NDIG-1:0]   an,
  output logic [6:0]        seg,
  output logic              scan_tick,
  output logic              bcd_err
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [NDIG-1:0] AN_IDLE  = ACTIVE_LOW ? '1 : '0;
  localparam seg7_t           SEG_IDLE = ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;

  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NDIG-1:0][3:0]   hold_q, hold_d;
  logic                   scan_tick_q, scan_tick_d;
  logic [NDIG-1:0]        an_q, an_d;
  seg7_t                  seg_q, seg_d;
  logic                   bcd_err_q, bcd_err_d;

  logic                   tick;
  logic                   blank;
  bcd_t                   cur_bcd;
  seg7_t                  dec_seg;
  seg7_t                  seg_hi;
  logic                   dec_err;
  logic [NDIG-1:0]        an_hot;

  bcd_to_seg7 u_dec (
    .bcd (cur_bcd),
    .seg (dec_seg),
    .err (dec_err)
  );

`ifdef BCD_SCAN_LZ_BLANK_EN
  // A digit is blanked when it and every more significant digit hold zero; digit 0 never blanks.
  logic [NDIG-1:0] lz_mask;
  logic            zero_run;

  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int i = NDIG - 1; i > 0; i--) begin
      zero_run   = zero_run & (hold_q[i] == 4'd0);
      lz_mask[i] = zero_run;
    end
    blank = lz_mask[idx_q];
  end
`else
  always_comb begin
    blank = 1'b0;
  end
`endif

  // Prescaler, scan index and hold register next state
  always_comb begin
    tick        = (cnt_q == CNT_W'(PRESCALE - 1));
    cnt_d       = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d       = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_W'(NDIG - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    hold_d      = latch ? digits_in : hold_q;
    scan_tick_d = tick;
  end

  // Output stage decodes the digit selected by the current index and applies polarity
  always_comb begin
    cur_bcd   = hold_q[idx_q];
    an_hot    = NDIG'(1) << idx_q;
    seg_hi    = blank ? SEG_OFF : dec_seg;
    an_d      = ACTIVE_LOW ? ~an_hot : an_hot;
    seg_d     = ACTIVE_LOW ? ~seg_hi : seg_hi;
    bcd_err_d = dec_err;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      hold_q      <= '0;
      scan_tick_q <= 1'b0;
      an_q        <= AN_IDLE;
      seg_q       <= SEG_IDLE;
      bcd_err_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      scan_tick_q <= scan_tick_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      bcd_err_q   <= bcd_err_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign scan_tick = scan_tick_q;
  assign bcd_err   = bcd_err_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display: edge-count reference model plus directed literal checks.
module tb_bcd_scan_display;

`ifdef BCD_SCAN_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr;
  logic [15:0] digits_in;
  logic        latch;
  logic [3:0]  an0, an1;
  logic [6:0]  seg0, seg1;
  logic        scan_tick0, scan_tick1;
  logic        bcd_err0, bcd_err1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  bcd_scan_display #(.NDIG(4), .PRESCALE(4), .ACTIVE_LOW(1'b1)) dut0 (
    .clk(clk), .clr(clr), .digits_in(digits_in), .latch(latch),
    .an(an0), .seg(seg0), .scan_tick(scan_tick0), .bcd_err(bcd_err0)
  );

  bcd_scan_display #(.NDIG(4), .PRESCALE(1), .ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .clr(clr), .digits_in(digits_in), .latch(latch),
    .an(an1), .seg(seg1), .scan_tick(scan_tick1), .bcd_err(bcd_err1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  // Model state: edges since reset, held word after the last edge and after the one before
  int          e_m = 0;
  logic [15:0] mh  = '0;
  logic [15:0] mhp = '0;

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      e_m <= 0;
      mh  <= '0;
      mhp <= '0;
    end else begin
      e_m <= e_m + 1;
      mhp <= mh;
      if (latch) mh <= digits_in;
    end
  end

  // Outputs after edge e show digit floor((e-1)/p) mod 4 of the word held after edge e-1
  function automatic void exp_out(input int e, input int p, input logic [15:0] h, input logic rst,
                                  output logic [3:0] a, output logic [6:0] s,
                                  output logic t, output logic er);
    int          i;
    logic [3:0]  nib;
    logic        blank;
    if (rst || e == 0) begin
      a = 4'hF; s = 7'h7F; t = 1'b0; er = 1'b0;
      return;
    end
    i     = ((e - 1) / p) % 4;
    nib   = 4'((h >> (4 * i)) & 16'hF);
    blank = LZ && (i > 0) && ((h >> (4 * i)) == 16'h0);
    a     = ~(4'(1) << i);
    s     = blank ? 7'h7F : ~seg_of(nib);
    t     = ((e % p) == 0);
    er    = (nib > 4'd9);
  endfunction

  always @(negedge clk) begin : compare
    logic [3:0] ea;
    logic [6:0] es;
    logic       et, ee;
    if (chk_en) begin
      exp_out(e_m, 4, mhp, clr, ea, es, et, ee);
      chk("p4_an", an0, ea);
      chk("p4_seg", seg0, es);
      chk("p4_scan_tick", scan_tick0, et);
      chk("p4_bcd_err", bcd_err0, ee);
      exp_out(e_m, 1, mhp, clr, ea, es, et, ee);
      chk("p1_an", an1, ea);
      chk("p1_seg", seg1, es);
      chk("p1_scan_tick", scan_tick1, et);
      chk("p1_bcd_err", bcd_err1, ee);
    end
  end

  task automatic do_latch(input logic [15:0] v);
    digits_in = v;
    latch     = 1'b1;
    @(negedge clk);
    latch     = 1'b0;
  endtask

  task automatic wait_an(input logic [3:0] tgt, input string nm);
    int n = 0;
    @(negedge clk);
    while (an0 !== tgt && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_an"}, an0, tgt);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int         n;
    logic [3:0] an_old;
    logic [3:0] prev;
    clr = 1'b0; digits_in = '0; latch = 1'b0;
    #3 clr = 1'b1;
    repeat (2) @(negedge clk);
    clr    = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_first_an", an0, 4'b1110);
    chk("rst_first_seg", seg0, 7'h40);
    repeat (5) @(negedge clk);

    // Asynchronous clear in the middle of a cycle
    @(posedge clk);
    #1 clr = 1'b1;
    #1;
    chk("midclr_an", an0, 4'b1111);
    chk("midclr_seg", seg0, 7'h7F);
    chk("midclr_tick", scan_tick0, 1'b0);
    chk("midclr_err", bcd_err0, 1'b0);
    chk("midclr_an_p1", an1, 4'b1111);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    chk("midclr_rel_an", an0, 4'b1110);
    chk("midclr_rel_seg", seg0, 7'h40);

    // Scan order; digit 0 is the least significant nibble
    do_latch(16'h1234);
    wait_an(4'b1110, "scan_d0");
    chk("scan_d0_seg", seg0, 7'h19);
    wait_an(4'b1101, "scan_d1");
    chk("scan_d1_seg", seg0, 7'h30);
    n = 1;
    while (n < 20) begin
      @(negedge clk);
      if (an0 !== 4'b1101) break;
      n++;
    end
    chk("scan_dwell", 32'(n), 32'd4);
    chk("scan_d2_an", an0, 4'b1011);
    chk("scan_d2_seg", seg0, 7'h24);
    wait_an(4'b0111, "scan_d3");
    chk("scan_d3_seg", seg0, 7'h79);

    // Invalid nibble on digit 1
    do_latch(16'h00A0);
    wait_an(4'b1101, "inv_d1");
    chk("inv_d1_seg", seg0, 7'h3F);
    chk("inv_d1_err", bcd_err0, 1'b1);
    wait_an(4'b1110, "inv_d0");
    chk("inv_d0_seg", seg0, 7'h40);
    chk("inv_d0_err", bcd_err0, 1'b0);

    // Latch on the same edge as a scan tick
    do_latch(16'h1111);
    n = 0;
    while (scan_tick0 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("coin_tick_found", scan_tick0, 1'b1);
    repeat (3) @(negedge clk);
    digits_in = 16'h9999;
    latch     = 1'b1;
    @(negedge clk);
    latch  = 1'b0;
    an_old = an0;
    chk("coin_old_seg", seg0, 7'h79);
    @(negedge clk);
    chk("coin_adv", 32'(an0 != an_old), 32'd1);
    chk("coin_new_seg", seg0, 7'h10);

    // PRESCALE=1 instance advances every cycle
    repeat (6) begin
      prev = an1;
      @(negedge clk);
      chk("p1_tick_high", scan_tick1, 1'b1);
      chk("p1_advance", 32'(an1 != prev), 32'd1);
    end

    // Leading zeros
    do_latch(16'h0050);
    wait_an(4'b0111, "lz_d3");
    chk("lz_d3_seg", seg0, LZ ? 7'h7F : 7'h40);
    wait_an(4'b1011, "lz_d2");
    chk("lz_d2_seg", seg0, LZ ? 7'h7F : 7'h40);
    wait_an(4'b1101, "lz_d1");
    chk("lz_d1_seg", seg0, 7'h12);
    wait_an(4'b1110, "lz_d0");
    chk("lz_d0_seg", seg0, 7'h40);

    // Randomized digits, latch pulses and occasional mid-cycle clears
    for (int k = 0; k < 700; k++) begin
      if ($urandom_range(0, 99) == 0) begin
        @(posedge clk);
        #1 clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
      end else begin
        @(negedge clk);
        digits_in = 16'($urandom);
        if ($urandom_range(0, 3) == 0) digits_in = digits_in & 16'h0F0F;
        latch = ($urandom_range(0, 3) == 0);
      end
    end
    latch = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
